// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo -- synchronous first-word-fall-through FIFO built on a circular buffer.
//
// Parameters
//   width : bits per data word
//   depth : number of storable words (power of two, >= 2)
//
// Ports
//   clk         : clock, all state changes on its rising edge
//   rst_n       : asynchronous active-low reset (clears pointers and count)
//   dato_i      : write data, captured when push_i is sampled high
//   push_i      : enqueue request
//   pop_i       : dequeue request
//   dato_o      : head word (combinational from storage), 0 when empty
//   full_o      : count equals depth
//   empty_o     : count equals zero
//   count_o     : number of stored words
//   overflow_o  : one-cycle pulse after a push was dropped
//   underflow_o : one-cycle pulse after a pop was ignored
// -----------------------------------------------------------------------------
module fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [width-1:0]           dato_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    output logic [width-1:0]           dato_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(depth):0]     count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int aw = $clog2(depth);
    // depth is a power of two, so "full" is just the MSB of the count set.
    localparam logic [aw:0] full_cnt = {1'b1, {aw{1'b0}}};

    logic [width-1:0] mem [depth];

    logic [aw-1:0] wr_ptr_reg;
    logic [aw-1:0] rd_ptr_reg;
    logic [aw:0]   count_reg;
    logic          overflow_reg;
    logic          underflow_reg;

    logic          is_empty;
    logic          is_full;
    logic          do_pop;
    logic          do_push;

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == full_cnt);

    // A pop only happens when there is something to remove. A push into a
    // full FIFO is still accepted when the same cycle frees a slot.
    assign do_pop  = pop_i && !is_empty;
    assign do_push = push_i && (!is_full || do_pop);

    // Storage has no reset: after a reset the pointers and count alone make
    // any stale contents unreachable. Writes are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (do_push && rst_n) begin
            mem[wr_ptr_reg] <= dato_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            // Pointers wrap naturally because depth is a power of two.
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
            overflow_reg  <= push_i && !do_push;
            underflow_reg <= pop_i && is_empty;
        end
    end

    assign dato_o      = is_empty ? '0 : mem[rd_ptr_reg];
    assign full_o      = is_full;
    assign empty_o     = is_empty;
    assign count_o     = count_reg;
    assign overflow_o  = overflow_reg;
    assign underflow_o = underflow_reg;

endmodule

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo -- directed, self-checking bench for fifo (width 16, depth 8).
// A reference queue holds the words the FIFO should contain; popped entries
// are compared against the DUT head, and status outputs against the queue.
// -----------------------------------------------------------------------------
module tb_fifo;

    localparam int W = 16;
    localparam int D = 8;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  dato_i;
    logic          push_i;
    logic          pop_i;
    logic [W-1:0]  dato_o;
    logic          full_o;
    logic          empty_o;
    logic [3:0]    count_o;
    logic          overflow_o;
    logic          underflow_o;

    int total;
    int bad;
    logic [W-1:0] sb [$];

    fifo #(.width(W), .depth(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dato_i      (dato_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .dato_o      (dato_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every status output against the reference queue.
    task automatic chk_state(input string tag, input logic exp_ovf, input logic exp_unf);
        logic [W-1:0] head;
        head = (sb.size() > 0) ? sb[0] : '0;
        chk({tag, ".count"}, 32'(count_o), 32'(sb.size()));
        chk({tag, ".empty"}, 32'(empty_o), 32'(sb.size() == 0));
        chk({tag, ".full"},  32'(full_o),  32'(sb.size() == D));
        chk({tag, ".dato"},  32'(dato_o),  32'(head));
        chk({tag, ".ovf"},   32'(overflow_o),  32'(exp_ovf));
        chk({tag, ".unf"},   32'(underflow_o), 32'(exp_unf));
    endtask

    // One clock cycle of stimulus; inputs driven mid-cycle, results sampled
    // 1 time unit after the rising edge.
    task automatic step(input string tag, input logic p, input logic o, input logic [W-1:0] d);
        logic exp_ovf;
        logic exp_unf;
        logic [W-1:0] popped;
        push_i = p;
        pop_i  = o;
        dato_i = d;
        exp_unf = o && (sb.size() == 0);
        exp_ovf = p && !o && (sb.size() == D);
        if (o && sb.size() > 0) begin
            popped = sb.pop_front();
            chk({tag, ".pophead"}, 32'(dato_o), 32'(popped));
        end
        if (p && !exp_ovf) sb.push_back(d);
        @(posedge clk);
        #1;
        push_i = 1'b0;
        pop_i  = 1'b0;
        $display("step %s push=%0b pop=%0b din=%0h -> dout=%0h count=%0d ovf=%0b unf=%0b",
                 tag, p, o, d, dato_o, count_o, overflow_o, underflow_o);
        chk_state(tag, exp_ovf, exp_unf);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        push_i = 1'b0;
        pop_i  = 1'b0;
        dato_i = '0;

        // Reset state, held across an edge.
        #12;
        chk_state("reset", 1'b0, 1'b0);
        rst_n = 1'b1;

        // Two pushes then two pops.
        step("push6", 1'b1, 1'b0, 16'h6);
        step("pushA", 1'b1, 1'b0, 16'hA);
        step("pop1",  1'b0, 1'b1, 16'h0);
        step("pop2",  1'b0, 1'b1, 16'h0);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, W'(i));
        step("push9_ovf", 1'b1, 1'b0, 16'h9);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 16'h0);

        // Underflow, then push+pop on empty.
        step("pop_empty",    1'b0, 1'b1, 16'h0);
        step("pushpop_empty", 1'b1, 1'b1, 16'h3);
        step("pop3",         1'b0, 1'b1, 16'h0);

        // Push+pop when full.
        for (int i = 0; i < 8; i++) step("fill2", 1'b1, 1'b0, W'(16'h20 + i));
        step("pushpop_full", 1'b1, 1'b1, 16'hB);
        for (int i = 0; i < 7; i++) step("drain2", 1'b0, 1'b1, 16'h0);
        chk("head_is_B", 32'(dato_o), 32'h000B);
        step("popB", 1'b0, 1'b1, 16'h0);

        // Pseudo-random mix exercising pointer wrap.
        for (int i = 0; i < 60; i++) begin
            step("mix", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 W'($urandom_range(0, 16'hFFFF)));
        end

        // Asynchronous reset mid-cycle with words stored.
        while (sb.size() > 0) step("flush", 1'b0, 1'b1, 16'h0);
        step("r1", 1'b1, 1'b0, 16'h11);
        step("r2", 1'b1, 1'b0, 16'h12);
        step("r3", 1'b1, 1'b0, 16'h13);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_state("async_rst", 1'b0, 1'b0);
        // Requests while in reset are ignored.
        push_i = 1'b1;
        pop_i  = 1'b1;
        dato_i = 16'h77;
        @(posedge clk);
        #1;
        push_i = 1'b0;
        pop_i  = 1'b0;
        chk_state("in_rst", 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        step("push5", 1'b1, 1'b0, 16'h5);
        chk("after_rst_head", 32'(dato_o), 32'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
